// File: rtl/z16_pkg.sv
// Shared Z16 definitions: word and address widths plus the instruction-loader state encoding.
package z16_pkg;

    localparam int unsigned Z16_WORD_W  = 16;
    localparam int unsigned Z16_BADDR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StWLo,
        StWHi,
        StWrite,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/z16_instr_loader.sv
// Byte-stream loader for the Z16 instruction store: reads a word-count header, then writes
// little-endian words to consecutive even byte addresses and releases the CPU when complete.
module z16_instr_loader
    import z16_pkg::*;
#(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [7:0]             i_byte,
    input  logic                   i_byte_valid,
    output logic                   o_byte_ready,
    output logic                   o_we,
    output logic [Z16_BADDR_W-1:0] o_waddr,
    output logic [Z16_WORD_W-1:0]  o_wdata,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_error,
    output logic                   o_cpu_run
);

    localparam logic [16:0] DepthW = 17'(DEPTH);

    loader_state_e state_q, state_d;
    logic [7:0]    n_lo_q, lo_q;
    logic [15:0]   n_q, idx_q, hdr_n, idx_inc;
    logic          xfer;

    assign xfer    = i_byte_valid && o_byte_ready;
    assign hdr_n   = {i_byte, n_lo_q};
    assign idx_inc = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StError: if (i_start) state_d = StHdrLo;
            StHdrLo: if (xfer) state_d = StHdrHi;
            StHdrHi: begin
                if (xfer) begin
                    if (hdr_n == 16'd0)               state_d = StDone;
                    else if ({1'b0, hdr_n} > DepthW)  state_d = StError;
                    else                              state_d = StWLo;
                end
            end
            StWLo:   if (xfer) state_d = StWHi;
            StWHi:   if (xfer) state_d = StWrite;
            StWrite: state_d = (idx_inc == n_q) ? StDone : StWLo;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= StIdle;
            n_lo_q       <= '0;
            n_q          <= '0;
            idx_q        <= '0;
            lo_q         <= '0;
            o_byte_ready <= 1'b0;
            o_we         <= 1'b0;
            o_waddr      <= '0;
            o_wdata      <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_cpu_run    <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_byte_ready <= state_d inside {StHdrLo, StHdrHi, StWLo, StWHi};
            o_busy       <= state_d inside {StHdrLo, StHdrHi, StWLo, StWHi, StWrite};
            o_we         <= (state_d == StWrite);
            o_done       <= (state_d == StDone);
            o_cpu_run    <= (state_d == StDone);
            o_error      <= (state_d == StError);

            if (state_q == StHdrLo && xfer) n_lo_q <= i_byte;
            if (state_q == StHdrHi && xfer) begin
                n_q   <= hdr_n;
                idx_q <= '0;
            end
            if (state_q == StWLo && xfer) lo_q <= i_byte;
            if (state_q == StWHi && xfer) begin
                o_waddr <= idx_q << 1;
                o_wdata <= {i_byte, lo_q};
            end
            if (state_q == StWrite) idx_q <= idx_inc;
        end
    end

endmodule
